// File: rtl/result_argmax_capture.sv
// Consumer end of the inference result stream: frames CLASSES signed scores into one
// inference, latches the argmax index/score, drives a one-hot LED view and counts inferences.
module result_argmax_capture #(
  parameter int  CLASSES    = 10,
  parameter int  DATA_WIDTH = 16,
  parameter int  TIMEOUT    = 1024,
  localparam int IDX_WIDTH  = (CLASSES > 1) ? $clog2(CLASSES) : 1
) (
  input  logic                  clock,
  input  logic                  areset,
  input  logic                  result_valid,
  input  logic [DATA_WIDTH-1:0] result_data,
  input  logic                  clear,
  output logic                  class_valid,
  output logic [IDX_WIDTH-1:0]  class_index,
  output logic [DATA_WIDTH-1:0] class_score,
  output logic [9:0]            led,
  output logic [15:0]           inference_count,
  output logic                  frame_error
);

  localparam int TMR_WIDTH = $clog2(TIMEOUT + 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

  state_t                r_state;
  logic [IDX_WIDTH-1:0]  r_idx;
  logic [DATA_WIDTH-1:0] r_best;
  logic [IDX_WIDTH-1:0]  r_best_idx;
  logic [TMR_WIDTH-1:0]  r_timer;
  logic                  r_class_valid;
  logic [IDX_WIDTH-1:0]  r_class_index;
  logic [DATA_WIDTH-1:0] r_class_score;
  logic [9:0]            r_led;
  logic [15:0]           r_inference_count;
  logic                  r_frame_error;

  logic                  w_score_wins;
  logic [DATA_WIDTH-1:0] w_next_best;
  logic [IDX_WIDTH-1:0]  w_next_best_idx;
  logic                  w_last_score;
  logic                  w_complete;

  // Indices 10 and above have no LED, so they fall out of the loop as all zero.
  function automatic logic [9:0] led_onehot(input logic [IDX_WIDTH-1:0] idx);
    logic [9:0] v;
    v = 10'd0;
    for (int i = 0; i < 10; i++) begin
      v[i] = (int'(idx) == i);
    end
    return v;
  endfunction

  // Post-compare best value/index as if the score on result_data were accepted now.
  always_comb begin
    w_score_wins    = ($signed(result_data) > $signed(r_best));
    w_next_best     = r_best;
    w_next_best_idx = r_best_idx;
    w_last_score    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_next_best     = result_data;
        w_next_best_idx = '0;
        w_last_score    = (CLASSES == 1);
      end
      S_ACCUM: begin
        if (w_score_wins) begin
          w_next_best     = result_data;
          w_next_best_idx = r_idx;
        end else begin
          w_next_best     = r_best;
          w_next_best_idx = r_best_idx;
        end
        w_last_score = (r_idx == IDX_WIDTH'(CLASSES - 1));
      end
      default: begin
        w_next_best     = r_best;
        w_next_best_idx = r_best_idx;
        w_last_score    = 1'b0;
      end
    endcase
    w_complete = result_valid & ~clear & w_last_score;
  end

  // Frame sequencing, inter-score timeout and the latched result registers.
  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      r_state           <= S_IDLE;
      r_idx             <= '0;
      r_best            <= '0;
      r_best_idx        <= '0;
      r_timer           <= '0;
      r_class_valid     <= 1'b0;
      r_class_index     <= '0;
      r_class_score     <= '0;
      r_led             <= 10'd0;
      r_inference_count <= 16'd0;
      r_frame_error     <= 1'b0;
    end else begin
      r_class_valid <= w_complete;
      r_frame_error <= 1'b0;

      if (w_complete) begin
        r_class_index     <= w_next_best_idx;
        r_class_score     <= w_next_best;
        r_led             <= led_onehot(w_next_best_idx);
        r_inference_count <= r_inference_count + 16'd1;
      end

      // clear outranks a simultaneous score, which is simply dropped.
      if (clear) begin
        r_state <= S_IDLE;
        r_idx   <= '0;
        r_timer <= '0;
      end else if (result_valid) begin
        r_best     <= w_next_best;
        r_best_idx <= w_next_best_idx;
        r_timer    <= '0;
        if (w_last_score) begin
          r_state <= S_IDLE;
          r_idx   <= '0;
        end else begin
          r_state <= S_ACCUM;
          r_idx   <= r_idx + IDX_WIDTH'(1);
        end
      end else if (r_state == S_ACCUM) begin
        if (r_timer == TMR_WIDTH'(TIMEOUT - 1)) begin
          r_frame_error <= 1'b1;
          r_state       <= S_IDLE;
          r_idx         <= '0;
          r_timer       <= '0;
        end else begin
          r_timer <= r_timer + TMR_WIDTH'(1);
        end
      end else begin
        r_timer <= '0;
      end
    end
  end

  assign class_valid     = r_class_valid;
  assign class_index     = r_class_index;
  assign class_score     = r_class_score;
  assign led             = r_led;
  assign inference_count = r_inference_count;
  assign frame_error     = r_frame_error;

endmodule

// File: tb/tb_result_argmax_capture.sv
// Directed bench for result_argmax_capture: table-driven frames plus hand sequences for
// back-to-back frames, timeout, clear, asynchronous reset and counter wrap.
module tb_result_argmax_capture;

  logic        clock = 1'b0;
  logic        areset;
  logic        result_valid;
  logic [15:0] result_data;
  logic        clear;
  logic        class_valid;
  logic [3:0]  class_index;
  logic [15:0] class_score;
  logic [9:0]  led;
  logic [15:0] inference_count;
  logic        frame_error;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [15:0] exp_cnt  = 16'd0;

  typedef struct packed {
    logic [9:0][15:0] s;
    logic [3:0]       idx;
    logic [15:0]      score;
  } vec_t;

  vec_t vecs [5];
  vec_t b2;

  result_argmax_capture #(
    .CLASSES    (10),
    .DATA_WIDTH (16),
    .TIMEOUT    (1024)
  ) dut (
    .clock           (clock),
    .areset          (areset),
    .result_valid    (result_valid),
    .result_data     (result_data),
    .clear           (clear),
    .class_valid     (class_valid),
    .class_index     (class_index),
    .class_score     (class_score),
    .led             (led),
    .inference_count (inference_count),
    .frame_error     (frame_error)
  );

  always #5 clock = ~clock;

  function automatic logic [9:0][15:0] f10(input int a0, input int a1, input int a2,
                                           input int a3, input int a4, input int a5,
                                           input int a6, input int a7, input int a8,
                                           input int a9);
    int               t [10];
    logic [9:0][15:0] r;
    t = '{a0, a1, a2, a3, a4, a5, a6, a7, a8, a9};
    for (int i = 0; i < 10; i++) r[i] = 16'(t[i]);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    result_valid = 1'b1;
    result_data  = d;
    step();
  endtask

  task automatic run_frame(input logic [9:0][15:0] s);
    for (int i = 0; i < 10; i++) send(s[i]);
    result_valid = 1'b0;
  endtask

  // Called one cycle after the final score edge.
  task automatic chk_done(input logic [3:0] idx, input logic [15:0] sc, input string nm);
    logic [9:0] e_led;
    e_led   = 10'd1 << idx;
    exp_cnt = exp_cnt + 16'd1;
    chk({nm, "_valid"}, 32'(class_valid), 32'd1);
    chk({nm, "_index"}, 32'(class_index), 32'(idx));
    chk({nm, "_score"}, 32'(class_score), 32'(sc));
    chk({nm, "_led"},   32'(led),         32'(e_led));
    chk({nm, "_count"}, 32'(inference_count), 32'(exp_cnt));
    step();
    chk({nm, "_pulse_end"}, 32'(class_valid), 32'd0);
  endtask

  initial begin
    int p1, p2, npulse, bad, spur;

    vecs[0] = '{f10(5, -3, 7, 2, 7, 0, -1, 4, 6, 1), 4'd2, 16'd7};
    vecs[1] = '{f10(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768,
                    -32768, 32767), 4'd9, 16'h7FFF};
    vecs[2] = '{f10(-100, -100, -100, -100, -100, -100, -5, -100, -100, -100),
                4'd6, 16'hFFFB};
    vecs[3] = '{f10(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768,
                    -32768, -32768), 4'd0, 16'h8000};
    vecs[4] = '{f10(0, 1, 2, 3, 4, 5, 6, 7, 8, 9), 4'd9, 16'd9};
    b2      = '{f10(1, 2, 3, 4, 5, 6, 7, 8, 50, 9), 4'd8, 16'd50};

    areset       = 1'b1;
    result_valid = 1'b0;
    result_data  = 16'd0;
    clear        = 1'b0;
    #12;
    chk("rst_valid", 32'(class_valid), 32'd0);
    chk("rst_index", 32'(class_index), 32'd0);
    chk("rst_score", 32'(class_score), 32'd0);
    chk("rst_led",   32'(led), 32'd0);
    chk("rst_count", 32'(inference_count), 32'd0);
    chk("rst_ferr",  32'(frame_error), 32'd0);
    areset = 1'b0;
    step();

    for (int v = 0; v < 5; v++) begin
      run_frame(vecs[v].s);
      chk_done(vecs[v].idx, vecs[v].score, $sformatf("vec%0d", v));
    end

    // Two frames with no gap: pulses must land exactly ten cycles apart.
    p1 = 0; p2 = 0; npulse = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k <= 10) send(vecs[0].s[k-1]);
      else         send(b2.s[k-11]);
      if (class_valid) begin
        npulse++;
        if (p1 == 0) p1 = k;
        else         p2 = k;
      end
      if (k == 10) chk("b2b_first_index", 32'(class_index), 32'd2);
    end
    result_valid = 1'b0;
    exp_cnt = exp_cnt + 16'd2;
    chk("b2b_first_at", 32'(p1), 32'd10);
    chk("b2b_gap", 32'(p2 - p1), 32'd10);
    chk("b2b_pulses", 32'(npulse), 32'd2);
    chk("b2b_index", 32'(class_index), 32'd8);
    chk("b2b_led", 32'(led), 32'h100);
    chk("b2b_count", 32'(inference_count), 32'(exp_cnt));
    step();
    chk("b2b_pulse_end", 32'(class_valid), 32'd0);

    // Partial frame then silence: error pulse after the 1024th idle cycle only.
    for (int i = 0; i < 4; i++) send(vecs[4].s[i]);
    result_valid = 1'b0;
    bad = 0;
    for (int k = 1; k <= 1023; k++) begin
      step();
      if (frame_error || class_valid) bad++;
    end
    chk("timeout_early", 32'(bad), 32'd0);
    step();
    chk("timeout_pulse", 32'(frame_error), 32'd1);
    chk("timeout_valid", 32'(class_valid), 32'd0);
    chk("timeout_index_held", 32'(class_index), 32'd8);
    chk("timeout_score_held", 32'(class_score), 32'd50);
    chk("timeout_count_held", 32'(inference_count), 32'(exp_cnt));
    step();
    chk("timeout_pulse_end", 32'(frame_error), 32'd0);
    run_frame(vecs[2].s);
    chk_done(vecs[2].idx, vecs[2].score, "after_timeout");

    // clear with a simultaneous score drops both the partial frame and that score.
    spur = 0;
    for (int i = 0; i < 6; i++) begin
      send(vecs[0].s[i]);
      if (class_valid) spur++;
    end
    clear        = 1'b1;
    result_valid = 1'b1;
    result_data  = 16'd1000;
    step();
    clear = 1'b0;
    if (class_valid || frame_error) spur++;
    for (int i = 0; i < 10; i++) begin
      send(vecs[0].s[i]);
      if (i < 9 && class_valid) spur++;
    end
    result_valid = 1'b0;
    chk("clear_no_pulse", 32'(spur), 32'd0);
    chk_done(vecs[0].idx, vecs[0].score, "after_clear");

    // Asynchronous reset mid-frame zeroes outputs without waiting for a clock edge.
    for (int i = 0; i < 5; i++) send(vecs[1].s[i]);
    areset = 1'b1;
    #1;
    chk("arst_valid", 32'(class_valid), 32'd0);
    chk("arst_index", 32'(class_index), 32'd0);
    chk("arst_score", 32'(class_score), 32'd0);
    chk("arst_led",   32'(led), 32'd0);
    chk("arst_count", 32'(inference_count), 32'd0);
    result_valid = 1'b0;
    #1;
    areset  = 1'b0;
    exp_cnt = 16'd0;
    step();
    run_frame(vecs[1].s);
    chk_done(vecs[1].idx, vecs[1].score, "after_arst");

    // Counter wrap from 0xFFFF.
    force dut.r_inference_count = 16'hFFFF;
    step();
    release dut.r_inference_count;
    chk("wrap_preload", 32'(inference_count), 32'h0000FFFF);
    exp_cnt = 16'hFFFF;
    run_frame(vecs[0].s);
    chk_done(vecs[0].idx, vecs[0].score, "wrap");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
